// File: rtl/nor4_sweep_checker.sv
// Sweep/check engine: drives all 16 {a,b,c,d} vectors into a 4-input gate and scores e,f,g.
// Optional build macro NOR4_CHK_STOP_ON_ERR_EN: abort the sweep on the first mismatching vector.
module nor4_sweep_checker #(
    parameter int          HOLD_CYCLES   = 20,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_E         = 16'h0001,
    parameter logic [15:0] EXP_F         = 16'h0001,
    parameter logic [15:0] EXP_G         = 16'h0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_vec,
    output logic       first_err_valid
);

    // state | meaning
    // IDLE  | waiting for start, stimulus parked at 0000
    // RUN   | holding vector vec for HOLD_CYCLES, sampling at SETTLE_CYCLES
    // DONE  | one-cycle done pulse, pass verdict latched on exit
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] SETTLE_AT = HW'(SETTLE_CYCLES);

    state_t        state, state_nxt;
    logic [3:0]    vec, vec_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [4:0]    err_nxt;
    logic [3:0]    fev_nxt;
    logic          fev_valid_nxt;
    logic          pass_nxt;
    logic          mismatch;
    logic          abort;
    logic [3:0]    stim;

    assign mismatch = (e != EXP_E[vec]) | (f != EXP_F[vec]) | (g != EXP_G[vec]);

    always_comb begin
        state_nxt     = state;
        vec_nxt       = vec;
        hold_nxt      = hold_cnt;
        err_nxt       = err_count;
        fev_nxt       = first_err_vec;
        fev_valid_nxt = first_err_valid;
        pass_nxt      = pass;
        abort         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = RUN;
                    vec_nxt       = 4'd0;
                    hold_nxt      = '0;
                    err_nxt       = 5'd0;
                    fev_nxt       = 4'd0;
                    fev_valid_nxt = 1'b0;
                    pass_nxt      = 1'b0;
                end
            end
            RUN: begin
                if (hold_cnt == SETTLE_AT && mismatch) begin
                    err_nxt = err_count + 5'd1;
                    if (!first_err_valid) begin
                        fev_nxt       = vec;
                        fev_valid_nxt = 1'b1;
                    end
`ifdef NOR4_CHK_STOP_ON_ERR_EN
                    abort     = 1'b1;
                    state_nxt = DONE;
`endif
                end
                if (!abort) begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (vec == 4'd15) begin
                            state_nxt = DONE;
                        end else begin
                            vec_nxt  = vec + 4'd1;
                            hold_nxt = '0;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                // err_count is already final here, including an abort's sample
                pass_nxt  = (err_count == 5'd0);
                state_nxt = IDLE;
                vec_nxt   = 4'd0;
                hold_nxt  = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec             <= 4'd0;
            hold_cnt        <= '0;
            err_count       <= 5'd0;
            first_err_vec   <= 4'd0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            stim            <= 4'd0;
        end else begin
            state           <= state_nxt;
            vec             <= vec_nxt;
            hold_cnt        <= hold_nxt;
            err_count       <= err_nxt;
            first_err_vec   <= fev_nxt;
            first_err_valid <= fev_valid_nxt;
            pass            <= pass_nxt;
            stim            <= (state_nxt == RUN) ? vec_nxt : 4'd0;
        end
    end

    assign {a, b, c, d} = stim;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nor4_sweep_checker.sv
// Bench for nor4_sweep_checker: a modelled gate with injectable faults, results scored via a queue.
module tb_nor4_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       a, b, c, d, e, f, g;
    logic       busy, done, pass, first_err_valid;
    logic [4:0] err_count;
    logic [3:0] first_err_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fmode = 0;
    int n_start = 0;

    typedef struct {
        int err;
        int fev;
        int fev_valid;
        int pass_exp;
        int done_cyc;
        int last_vec;
    } exp_t;
    exp_t sb_q[$];

    nor4_sweep_checker dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c(c), .d(d),
        .e(e), .f(f), .g(g),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_vec(first_err_vec),
        .first_err_valid(first_err_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // gate under test: 4-input NOR with fault modes 1 = g stuck 0, 2 = e stuck 1
    function automatic logic [2:0] gate_out(int mode, int v);
        logic nor_v;
        nor_v = (v == 0);
        return {(mode == 2) ? 1'b1 : nor_v, nor_v, (mode == 1) ? 1'b0 : nor_v};
    endfunction

    always_comb begin
        {e, f, g} = gate_out(fmode, int'({a, b, c, d}));
    end

    function automatic exp_t model(int mode, int n);
        exp_t r;
        r = '{err: 0, fev: 0, fev_valid: 0, pass_exp: 0, done_cyc: n + 321, last_vec: 15};
        for (int v = 0; v < 16; v++) begin
            if (gate_out(mode, v) != (v == 0 ? 3'b111 : 3'b000)) begin
                r.err++;
                if (r.fev_valid == 0) begin
                    r.fev = v;
                    r.fev_valid = 1;
                end
`ifdef NOR4_CHK_STOP_ON_ERR_EN
                r.done_cyc = n + 1 + v * 20 + 3;
                r.last_vec = v;
                break;
`endif
            end
        end
        r.pass_exp = (r.err == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // caller is at a negedge; start is sampled on the next rising edge
    task automatic start_sweep(input int mode);
        fmode = mode;
        start = 1'b1;
        n_start = cyc;
        sb_q.push_back(model(mode, n_start));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("errcnt_cleared", err_count, 0);
    endtask

    task automatic finish_sweep(input bit pulse_mid, input bit pulse_done);
        exp_t x;
        x = sb_q[0];
        while (!done && cyc < n_start + 400) begin
            if (busy && ((cyc - n_start - 1) % 20) == 10 && (cyc - n_start - 1) / 20 <= x.last_vec)
                chk("stim_vec", {a, b, c, d}, (cyc - n_start - 1) / 20);
            start = pulse_mid && (cyc == n_start + 50);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("done_cycle", cyc, x.done_cyc);
        chk("busy_in_done", busy, 0);
        chk("abcd_in_done", {a, b, c, d}, 0);
        void'(sb_q.pop_front());
        if (pulse_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("no_restart", busy, 0);
        chk("err_count", err_count, x.err);
        chk("first_err_vec", first_err_vec, x.fev);
        chk("first_err_valid", first_err_valid, x.fev_valid);
        chk("pass", pass, x.pass_exp);
    endtask

    initial begin
        int rmode;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_abcd", {a, b, c, d}, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_fev", {first_err_valid, first_err_vec}, 0);
        rst = 1'b0;
        @(negedge clk);

        start_sweep(0); finish_sweep(0, 0);
        start_sweep(1); finish_sweep(0, 0);
        start_sweep(2); finish_sweep(0, 0);

        // reset in the middle of vector 7
`ifdef NOR4_CHK_STOP_ON_ERR_EN
        rmode = 0;
`else
        rmode = 2;
`endif
        start_sweep(rmode);
        while (cyc < n_start + 145) @(negedge clk);
        chk("vec7_before_rst", {a, b, c, d}, 7);
        rst = 1'b1;
        void'(sb_q.pop_front());
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_abcd", {a, b, c, d}, 0);
        chk("rst_mid_errcnt", err_count, 0);
        chk("rst_mid_fev_valid", first_err_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        start_sweep(0); finish_sweep(0, 0);

        // stray starts mid-sweep and in DONE, then back-to-back start at DONE+1
        start_sweep(2); finish_sweep(1, 1);
        start_sweep(0);
        chk("restart_latency", cyc, sb_q[0].done_cyc - 320);
        finish_sweep(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
